// File: rtl/xfer_sched_pkg.sv
// Shared types and constants for the xfer_sched bus/RAM transfer scheduler.
package xfer_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, TURN} fsm_t;
  typedef enum logic {CAP, PLY} chan_t;

  localparam int unsigned LAT_MAX  = 4;
  localparam int unsigned TURN_MAX = 7;
  // One down-counter serves both the drain and turnaround phases
  localparam int unsigned CNT_W    = $clog2((LAT_MAX > TURN_MAX ? LAT_MAX : TURN_MAX) + 1);
  localparam int unsigned STAT_W   = 16;

endpackage

// File: rtl/xfer_sched_dly.sv
// Shift delay of a {strobe, address} pair with synchronous clear.
module xfer_sched_dly
  import xfer_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_stb,
  input  logic [W-1:0] in_addr,
  output logic         out_stb,
  output logic [W-1:0] out_addr
);

  logic [DEPTH-1:0]        stb_q, stb_d;
  logic [DEPTH-1:0][W-1:0] addr_q, addr_d;

  always_comb begin
    stb_d     = stb_q;
    addr_d    = addr_q;
    stb_d[0]  = in_stb;
    addr_d[0] = in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      stb_d[i]  = stb_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stb_q  <= '0;
      addr_q <= '0;
    end else begin
      stb_q  <= stb_d;
      addr_q <= addr_d;
    end
  end

  assign out_stb  = stb_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/xfer_sched.sv
// Round-robin capture/playback transfer scheduler with latency-compensated strobes.
// Optional completed-transfer counters are built when XFER_SCHED_STAT_EN is defined.
module xfer_sched
  import xfer_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WR_LAT   = 2,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_req,
  input  logic [ADDR_W-1:0] cap_base,
  input  logic [ADDR_W:0]   cap_len,
  output logic              cap_ack,
  output logic              cap_done,
  input  logic              ply_req,
  input  logic [ADDR_W-1:0] ply_base,
  input  logic [ADDR_W:0]   ply_len,
  output logic              ply_ack,
  output logic              ply_done,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_oe,
  output logic              busy,
  output logic [STAT_W-1:0] cap_cnt,
  output logic [STAT_W-1:0] ply_cnt
);

  localparam int unsigned     LEN_W   = ADDR_W + 1;
  localparam int unsigned     TURN_M1 = (TURN_CYC == 0) ? 0 : TURN_CYC - 1;
  localparam logic [LEN_W-1:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  function automatic logic [CNT_W-1:0] lat_of(input chan_t c);
    return (c == CAP) ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
  endfunction

  fsm_t              state_q, state_d;
  chan_t             chan_q, chan_d, last_q, last_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d, g_base, iss_addr;
  logic [LEN_W-1:0]  rem_q, rem_d, g_len;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              iss_stb, cap_iss, ply_iss;
  logic              cap_ack_q, cap_ack_d, ply_ack_q, ply_ack_d;
  logic              cap_done_q, cap_done_d, ply_done_q, ply_done_d;
  logic              ram_wren_q, ram_wren_d, bus_oe_q, bus_oe_d, busy_q, busy_d;
  logic [ADDR_W-1:0] ram_wraddr_q, ram_wraddr_d, ram_rdaddr_q, ram_rdaddr_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d, wr_addr, rd_addr;
  logic              wr_stb, rd_stb, dly_clr;

  // Round-robin pick: on a tie the channel not granted last wins
  always_comb begin
    if (cap_req && ply_req) pick = (last_q == PLY) ? CAP : PLY;
    else if (cap_req)       pick = CAP;
    else                    pick = PLY;
    g_base = (pick == CAP) ? cap_base : ply_base;
    g_len  = sat_len((pick == CAP) ? cap_len : ply_len);
  end

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    last_d     = last_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    cap_ack_d  = 1'b0;
    ply_ack_d  = 1'b0;
    cap_done_d = 1'b0;
    ply_done_d = 1'b0;
    iss_stb    = 1'b0;
    iss_addr   = addr_q;
    unique case (state_q)
      IDLE: begin
        if (cap_req || ply_req) begin
          chan_d    = pick;
          last_d    = pick;
          cap_ack_d = (pick == CAP);
          ply_ack_d = (pick == PLY);
          if (g_len == '0) begin
            state_d = DRAIN;
            cnt_d   = lat_of(pick);
          end else begin
            state_d  = RUN;
            iss_stb  = 1'b1;
            iss_addr = g_base;
            addr_d   = g_base + ADDR_W'(1);
            rem_d    = g_len - LEN_W'(1);
          end
        end
      end
      RUN: begin
        if (rem_q != '0) begin
          iss_stb = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
        end else begin
          state_d = DRAIN;
          cnt_d   = lat_of(chan_q);
        end
      end
      DRAIN: begin
        // Done is registered so it lands on the cycle after the last delayed strobe
        if (cnt_q == '0) begin
          if (TURN_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = TURN;
            cnt_d   = CNT_W'(TURN_M1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cap_done_d = (chan_q == CAP);
            ply_done_d = (chan_q == PLY);
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign cap_iss = iss_stb && (chan_d == CAP);
  assign ply_iss = iss_stb && (chan_d == PLY);
  assign dly_clr = ~rst_n;

  xfer_sched_dly #(.DEPTH(WR_LAT), .W(ADDR_W)) u_wr_dly (
    .clk(clk), .clr(dly_clr), .in_stb(cap_iss), .in_addr(iss_addr),
    .out_stb(wr_stb), .out_addr(wr_addr)
  );

  xfer_sched_dly #(.DEPTH(RD_LAT), .W(ADDR_W)) u_rd_dly (
    .clk(clk), .clr(dly_clr), .in_stb(ply_iss), .in_addr(iss_addr),
    .out_stb(rd_stb), .out_addr(rd_addr)
  );

  // Addresses hold when their strobe is idle
  always_comb begin
    ram_wren_d   = wr_stb;
    ram_wraddr_d = wr_stb ? wr_addr : ram_wraddr_q;
    ram_rdaddr_d = ply_iss ? iss_addr : ram_rdaddr_q;
    bus_oe_d     = rd_stb;
    bus_addr_d   = cap_iss ? iss_addr : (rd_stb ? rd_addr : bus_addr_q);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      chan_q       <= CAP;
      last_q       <= PLY;
      addr_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      cap_ack_q    <= 1'b0;
      ply_ack_q    <= 1'b0;
      cap_done_q   <= 1'b0;
      ply_done_q   <= 1'b0;
      ram_wren_q   <= 1'b0;
      ram_wraddr_q <= '0;
      ram_rdaddr_q <= '0;
      bus_oe_q     <= 1'b0;
      bus_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      cap_ack_q    <= cap_ack_d;
      ply_ack_q    <= ply_ack_d;
      cap_done_q   <= cap_done_d;
      ply_done_q   <= ply_done_d;
      ram_wren_q   <= ram_wren_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_rdaddr_q <= ram_rdaddr_d;
      bus_oe_q     <= bus_oe_d;
      bus_addr_q   <= bus_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign cap_ack    = cap_ack_q;
  assign ply_ack    = ply_ack_q;
  assign cap_done   = cap_done_q;
  assign ply_done   = ply_done_q;
  assign ram_wren   = ram_wren_q;
  assign ram_wraddr = ram_wraddr_q;
  assign ram_rdaddr = ram_rdaddr_q;
  assign bus_oe     = bus_oe_q;
  assign bus_addr   = bus_addr_q;
  assign busy       = busy_q;

`ifdef XFER_SCHED_STAT_EN
  logic [STAT_W-1:0] cap_cnt_q, cap_cnt_d, ply_cnt_q, ply_cnt_d;

  always_comb begin
    cap_cnt_d = cap_cnt_q + STAT_W'(cap_done_d);
    ply_cnt_d = ply_cnt_q + STAT_W'(ply_done_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_cnt_q <= '0;
      ply_cnt_q <= '0;
    end else begin
      cap_cnt_q <= cap_cnt_d;
      ply_cnt_q <= ply_cnt_d;
    end
  end

  assign cap_cnt = cap_cnt_q;
  assign ply_cnt = ply_cnt_q;
`else
  assign cap_cnt = '0;
  assign ply_cnt = '0;
`endif

endmodule
